// File: rtl/regfile_pkg.sv
// Shared register-file constants and small decode helpers used by the
// register file and its write-back path.
package regfile_pkg;

  localparam int REG_AW   = 5;
  localparam int REG_DW   = 32;
  localparam int NREG     = 32;
  localparam int WB_DEPTH = 4;

  // One-hot decode of a register address into an NREG-wide mask.
  function automatic logic [NREG-1:0] reg_onehot(input logic [REG_AW-1:0] addr);
    logic [NREG-1:0] one;
    one = {{(NREG-1){1'b0}}, 1'b1};
    return one << addr;
  endfunction

endpackage

// File: rtl/regfile_wb_fifo.sv
// Buffered long-latency results awaiting a register-file write slot.
// Each entry carries a live bit that a younger write to the same register clears.
module regfile_wb_fifo
  import regfile_pkg::*;
#(
  parameter int DEPTH = WB_DEPTH,
  parameter int AW    = REG_AW,
  parameter int DW    = REG_DW,
  parameter int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush_i,
  input  logic                      push_i,
  input  logic [AW-1:0]             push_addr_i,
  input  logic [DW-1:0]             push_data_i,
  input  logic                      pop_i,
  input  logic                      kill_i,
  input  logic [AW-1:0]             kill_addr_i,
  output logic [AW-1:0]             head_addr_o,
  output logic [DW-1:0]             head_data_o,
  output logic                      head_live_o,
  output logic [CW-1:0]             count_o,
  output logic [DEPTH-1:0]          live_o,
  output logic [DEPTH-1:0][AW-1:0]  addr_o
);

  logic [AW-1:0]    addr_q [DEPTH];
  logic [DW-1:0]    data_q [DEPTH];
  logic [DEPTH-1:0] live_q, live_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_s, pop_s;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? {PW{1'b0}} : p + PW'(1);
  endfunction

  assign push_s = push_i && !flush_i && (count_q != CW'(DEPTH));
  assign pop_s  = pop_i  && !flush_i && (count_q != {CW{1'b0}});

  // Next-state for pointers, occupancy and live bits; flush overrides everything.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    live_d   = live_q;
    if (flush_i) begin
      wr_ptr_d = {PW{1'b0}};
      rd_ptr_d = {PW{1'b0}};
      count_d  = {CW{1'b0}};
      live_d   = {DEPTH{1'b0}};
    end else begin
      // Kill sees only entries present before this edge; a same-edge push stays live.
      for (int i = 0; i < DEPTH; i++) begin
        live_d[i] = live_q[i] & ~(kill_i && (addr_q[i] == kill_addr_i));
      end
      if (pop_s) begin
        live_d[rd_ptr_q] = 1'b0;
        rd_ptr_d         = ptr_inc(rd_ptr_q);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      if (push_s) begin
        live_d[wr_ptr_q] = 1'b1;
        wr_ptr_d         = ptr_inc(wr_ptr_q);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= {PW{1'b0}};
      rd_ptr_q <= {PW{1'b0}};
      count_q  <= {CW{1'b0}};
      live_q   <= {DEPTH{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      live_q   <= live_d;
    end
  end

  // Entry storage, written at the tail on every accepted push.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= {AW{1'b0}};
        data_q[i] <= {DW{1'b0}};
      end
    end else if (push_s) begin
      addr_q[wr_ptr_q] <= push_addr_i;
      data_q[wr_ptr_q] <= push_data_i;
    end else begin
      addr_q[wr_ptr_q] <= addr_q[wr_ptr_q];
      data_q[wr_ptr_q] <= data_q[wr_ptr_q];
    end
  end

  // Flatten entry addresses for the pending decode in the parent.
  always_comb begin
    addr_o = '{default: {AW{1'b0}}};
    for (int i = 0; i < DEPTH; i++) begin
      addr_o[i] = addr_q[i];
    end
  end

  assign head_addr_o = addr_q[rd_ptr_q];
  assign head_data_o = data_q[rd_ptr_q];
  assign head_live_o = live_q[rd_ptr_q];
  assign count_o     = count_q;
  assign live_o      = live_q;

endmodule

// File: rtl/regfile_wb_writer.sv
// Register-file write-back arbiter: single-cycle ALU results win the write port,
// long-latency LSU results are buffered and drained in order when the port is free.
module regfile_wb_writer
  import regfile_pkg::*;
#(
  parameter int DEPTH = WB_DEPTH,
  parameter int AW    = REG_AW,
  parameter int DW    = REG_DW,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            alu_valid,
  input  logic [AW-1:0]   alu_addr,
  input  logic [DW-1:0]   alu_data,
  input  logic            lsu_valid,
  output logic            lsu_ready,
  input  logic [AW-1:0]   lsu_addr,
  input  logic [DW-1:0]   lsu_data,
  input  logic            flush,
  output logic            write_en,
  output logic [AW-1:0]   write_addr,
  output logic [DW-1:0]   write_data,
  output logic [NREG-1:0] pending,
  output logic [CW-1:0]   count
);

  logic                     alu_accept_s;
  logic                     lsu_push_s;
  logic                     pop_s;
  logic [AW-1:0]            head_addr_s;
  logic [DW-1:0]            head_data_s;
  logic                     head_live_s;
  logic [CW-1:0]            count_s;
  logic [DEPTH-1:0]         live_s;
  logic [DEPTH-1:0][AW-1:0] entry_addr_s;
  logic [NREG-1:0]          pending_s;

  logic            write_en_q, write_en_d;
  logic [AW-1:0]   write_addr_q, write_addr_d;
  logic [DW-1:0]   write_data_q, write_data_d;

  assign alu_accept_s = alu_valid && (alu_addr != {AW{1'b0}});
  assign lsu_ready    = (count_s < CW'(DEPTH));
  // Zero-address LSU results complete the handshake but are never stored.
  assign lsu_push_s   = lsu_valid && lsu_ready && (lsu_addr != {AW{1'b0}});
  assign pop_s        = !alu_accept_s && (count_s != {CW{1'b0}});

  regfile_wb_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .DW    (DW)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (flush),
    .push_i      (lsu_push_s),
    .push_addr_i (lsu_addr),
    .push_data_i (lsu_data),
    .pop_i       (pop_s),
    .kill_i      (alu_accept_s),
    .kill_addr_i (alu_addr),
    .head_addr_o (head_addr_s),
    .head_data_o (head_data_s),
    .head_live_o (head_live_s),
    .count_o     (count_s),
    .live_o      (live_s),
    .addr_o      (entry_addr_s)
  );

  // Write-port selection: ALU first, then a live queue head; killed heads issue nothing.
  always_comb begin
    write_en_d   = 1'b0;
    write_addr_d = write_addr_q;
    write_data_d = write_data_q;
    if (alu_accept_s) begin
      write_en_d   = 1'b1;
      write_addr_d = alu_addr;
      write_data_d = alu_data;
    end else if (pop_s && !flush && head_live_s) begin
      write_en_d   = 1'b1;
      write_addr_d = head_addr_s;
      write_data_d = head_data_s;
    end else begin
      write_en_d = 1'b0;
    end
  end

  // Registered register-file write port.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      write_en_q   <= 1'b0;
      write_addr_q <= {AW{1'b0}};
      write_data_q <= {DW{1'b0}};
    end else begin
      write_en_q   <= write_en_d;
      write_addr_q <= write_addr_d;
      write_data_q <= write_data_d;
    end
  end

  // Pending mask of registers with a live queued result; r0 is never pending.
  always_comb begin
    pending_s = {NREG{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      pending_s = pending_s | (reg_onehot(entry_addr_s[i]) & {NREG{live_s[i]}});
    end
    pending_s[0] = 1'b0;
  end

  assign write_en   = write_en_q;
  assign write_addr = write_addr_q;
  assign write_data = write_data_q;
  assign pending    = pending_s;
  assign count      = count_s;

endmodule

// File: tb/tb_regfile_wb_writer.sv
// Directed-vector bench for regfile_wb_writer with hand-computed expectations.
module tb_regfile_wb_writer;

  logic        clk;
  logic        rst;
  logic        alu_valid;
  logic [4:0]  alu_addr;
  logic [31:0] alu_data;
  logic        lsu_valid;
  logic        lsu_ready;
  logic [4:0]  lsu_addr;
  logic [31:0] lsu_data;
  logic        flush;
  logic        write_en;
  logic [4:0]  write_addr;
  logic [31:0] write_data;
  logic [31:0] pending;
  logic [2:0]  count;

  int n_vec = 0;
  int n_err = 0;

  regfile_wb_writer dut (
    .clk        (clk),
    .rst        (rst),
    .alu_valid  (alu_valid),
    .alu_addr   (alu_addr),
    .alu_data   (alu_data),
    .lsu_valid  (lsu_valid),
    .lsu_ready  (lsu_ready),
    .lsu_addr   (lsu_addr),
    .lsu_data   (lsu_data),
    .flush      (flush),
    .write_en   (write_en),
    .write_addr (write_addr),
    .write_data (write_data),
    .pending    (pending),
    .count      (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alu_valid = 1'b0; alu_addr = 5'd0; alu_data = 32'd0;
    lsu_valid = 1'b0; lsu_addr = 5'd0; lsu_data = 32'd0;
    flush     = 1'b0;
  endtask

  task automatic chk_wr(input string tag, input logic en, input logic [4:0] a, input logic [31:0] d);
    chk({tag, ".en"}, 64'(write_en), 64'(en));
    chk({tag, ".addr"}, 64'(write_addr), 64'(a));
    chk({tag, ".data"}, 64'(write_data), 64'(d));
  endtask

  initial begin
    idle();
    rst = 1'b0;
    tick();
    tick();
    chk("rst.en", 64'(write_en), 64'd0);
    chk("rst.count", 64'(count), 64'd0);
    chk("rst.pending", 64'(pending), 64'd0);
    chk("rst.ready", 64'(lsu_ready), 64'd1);
    rst = 1'b1;
    tick();

    // ALU-only write, then a write to r0 that must be dropped
    alu_valid = 1'b1; alu_addr = 5'd3; alu_data = 32'hDEAD_BEEF;
    tick();
    chk_wr("alu3", 1'b1, 5'd3, 32'hDEAD_BEEF);
    alu_addr = 5'd0; alu_data = 32'h0000_0055;
    tick();
    chk_wr("alu0", 1'b0, 5'd3, 32'hDEAD_BEEF);

    // Fill: ALU busy on r20 every cycle, LSU offers r1..r5
    for (int i = 1; i <= 5; i++) begin
      alu_valid = 1'b1; alu_addr = 5'd20; alu_data = 32'h0000_2000 + 32'(i);
      lsu_valid = 1'b1; lsu_addr = 5'(i); lsu_data = 32'h0000_0100 + 32'(i);
      chk($sformatf("fill.ready%0d", i), 64'(lsu_ready), (i <= 4) ? 64'd1 : 64'd0);
      tick();
    end
    chk_wr("fill.alu", 1'b1, 5'd20, 32'h0000_2005);
    chk("fill.count", 64'(count), 64'd4);
    chk("fill.pending", 64'(pending), 64'h1E);
    chk("fill.ready", 64'(lsu_ready), 64'd0);
    idle();
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk_wr($sformatf("drain%0d", k), 1'b1, 5'(k), 32'h0000_0100 + 32'(k));
      chk($sformatf("drain%0d.count", k), 64'(count), 64'(4 - k));
    end
    tick();
    chk_wr("drain.empty", 1'b0, 5'd4, 32'h0000_0104);
    chk("drain.pending", 64'(pending), 64'd0);

    // WAW squash: queued r7 killed by younger ALU write to r7
    lsu_valid = 1'b1; lsu_addr = 5'd7; lsu_data = 32'h0000_0011;
    tick();
    chk("sq.count", 64'(count), 64'd1);
    chk("sq.pending", 64'(pending), 64'h80);
    chk("sq.en0", 64'(write_en), 64'd0);
    idle();
    alu_valid = 1'b1; alu_addr = 5'd7; alu_data = 32'h0000_0022;
    tick();
    chk_wr("sq.alu", 1'b1, 5'd7, 32'h0000_0022);
    chk("sq.pending_clr", 64'(pending), 64'd0);
    chk("sq.count_held", 64'(count), 64'd1);
    idle();
    tick();
    chk_wr("sq.drain", 1'b0, 5'd7, 32'h0000_0022);
    chk("sq.count_end", 64'(count), 64'd0);

    // Same-cycle ALU and LSU to r9: LSU entry is younger and survives
    alu_valid = 1'b1; alu_addr = 5'd9; alu_data = 32'h0000_000A;
    lsu_valid = 1'b1; lsu_addr = 5'd9; lsu_data = 32'h0000_000B;
    tick();
    chk_wr("same.alu", 1'b1, 5'd9, 32'h0000_000A);
    chk("same.pending", 64'(pending), 64'h200);
    idle();
    tick();
    chk_wr("same.lsu", 1'b1, 5'd9, 32'h0000_000B);
    chk("same.count", 64'(count), 64'd0);

    // LSU offer to r0 handshakes but is not stored
    lsu_valid = 1'b1; lsu_addr = 5'd0; lsu_data = 32'h0000_0077;
    chk("r0.ready", 64'(lsu_ready), 64'd1);
    tick();
    chk("r0.count", 64'(count), 64'd0);
    chk("r0.en", 64'(write_en), 64'd0);
    idle();

    // Flush with three entries queued; ALU write still issues, new offer discarded
    for (int i = 0; i < 3; i++) begin
      alu_valid = 1'b1; alu_addr = 5'd21; alu_data = 32'h0000_0021;
      lsu_valid = 1'b1; lsu_addr = 5'(4 + i); lsu_data = 32'h0000_0040 + 32'(i);
      tick();
    end
    chk("fl.count3", 64'(count), 64'd3);
    chk("fl.pending3", 64'(pending), 64'h70);
    alu_valid = 1'b1; alu_addr = 5'd2; alu_data = 32'h0000_2222;
    lsu_valid = 1'b1; lsu_addr = 5'd8; lsu_data = 32'h0000_0088;
    flush = 1'b1;
    tick();
    chk_wr("fl.alu", 1'b1, 5'd2, 32'h0000_2222);
    chk("fl.count", 64'(count), 64'd0);
    chk("fl.pending", 64'(pending), 64'd0);
    idle();
    tick();
    chk_wr("fl.after", 1'b0, 5'd2, 32'h0000_2222);

    // Reset mid-operation with three entries queued
    for (int i = 0; i < 3; i++) begin
      alu_valid = 1'b1; alu_addr = 5'd21; alu_data = 32'h0000_0031;
      lsu_valid = 1'b1; lsu_addr = 5'(10 + i); lsu_data = 32'h0000_0050 + 32'(i);
      tick();
    end
    chk("mr.count3", 64'(count), 64'd3);
    chk("mr.en_before", 64'(write_en), 64'd1);
    idle();
    rst = 1'b0;
    #1;
    chk_wr("mr.async", 1'b0, 5'd0, 32'd0);
    chk("mr.count", 64'(count), 64'd0);
    chk("mr.pending", 64'(pending), 64'd0);
    chk("mr.ready", 64'(lsu_ready), 64'd1);
    tick();
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("mr.quiet%0d", k), 64'(write_en), 64'd0);
    end
    alu_valid = 1'b1; alu_addr = 5'd17; alu_data = 32'h0000_1717;
    tick();
    chk_wr("mr.first", 1'b1, 5'd17, 32'h0000_1717);
    idle();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
